// File: rtl/song_note_player_if.sv
// Bus between the song player and its environment.
// Control side: Start, Stop, SongLen in; Busy, Done out.
// Memory side:  RdEn, RdAddr out; RdData in.
// Tone side:    NoteOn, NotePitch out.
// The slave modport is the player; the master modport is whoever drives it.
interface song_note_player_if #(
  parameter int unsigned SONG_OUTPUT_LEN = 64,
  parameter int unsigned SONG_DIM        = 2,
  parameter int unsigned BIT_LEN         = 8,
  parameter int unsigned ADDR_W          = $clog2(SONG_OUTPUT_LEN)
);
  logic                        Start;
  logic                        Stop;
  logic [BIT_LEN-1:0]          SongLen;
  logic                        RdEn;
  logic [ADDR_W-1:0]           RdAddr;
  logic [SONG_DIM*BIT_LEN-1:0] RdData;
  logic                        NoteOn;
  logic [BIT_LEN-1:0]          NotePitch;
  logic                        Busy;
  logic                        Done;

  modport master (
    output Start, Stop, SongLen, RdData,
    input  RdEn, RdAddr, NoteOn, NotePitch, Busy, Done
  );

  modport slave (
    input  Start, Stop, SongLen, RdData,
    output RdEn, RdAddr, NoteOn, NotePitch, Busy, Done
  );
endinterface

// File: rtl/song_note_player.sv
// Reads a song out of note memory and plays it as a timed level stream.
// Each note word holds pitch in field 0 and duration (in ticks) in field 1.
// A note is fetched (FETCH), its word captured (WAIT), held for
// duration*TICK_DIV cycles (PLAY) and followed by GAP_CYCLES of silence (GAP).
// Zero-duration notes are skipped; pitch 0 plays as a rest (NoteOn low).
//
// Ports:
//   Clk    - clock, rising edge
//   Reset  - asynchronous, active-high
//   bus    - slave side of song_note_player_if:
//            Start/Stop/SongLen control, Busy/Done status,
//            RdEn/RdAddr/RdData note memory (1-cycle read latency),
//            NoteOn/NotePitch tone output. All outputs are registered.
//
// Optional feature macro: AMADEUS_PLAYER_LOOP_EN
//   defined   - after the last note playback wraps to note 0 forever (no Done)
//   undefined - single pass, Done pulses once at the end
module song_note_player #(
  parameter int unsigned SONG_OUTPUT_LEN = 64,
  parameter int unsigned SONG_DIM        = 2,
  parameter int unsigned BIT_LEN         = 8,
  parameter int unsigned TICK_DIV        = 1000,
  parameter int unsigned GAP_CYCLES      = 4,
  parameter int unsigned ADDR_W          = $clog2(SONG_OUTPUT_LEN)
) (
  input logic               Clk,
  input logic               Reset,
  song_note_player_if.slave bus
);

  // Len and Idx must be able to hold SONG_OUTPUT_LEN itself.
  localparam int unsigned LEN_W  = $clog2(SONG_OUTPUT_LEN + 1);
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TICK_W-1:0] TickLast = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GapLast  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StPlay,
    StGap
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [BIT_LEN-1:0] dur_q, dur_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               note_on_q, note_on_d;
  logic [BIT_LEN-1:0] note_pitch_q, note_pitch_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [BIT_LEN-1:0] rd_pitch;
  logic [BIT_LEN-1:0] rd_dur;
  logic [LEN_W-1:0]   len_clamped;
  logic [LEN_W-1:0]   idx_inc;
  logic               last_note;

  assign rd_pitch  = bus.RdData[BIT_LEN-1:0];
  assign rd_dur    = bus.RdData[2*BIT_LEN-1:BIT_LEN];
  assign idx_inc   = idx_q + LEN_W'(1);
  assign last_note = (idx_inc >= len_q);

  always_comb begin
    if (32'(bus.SongLen) > SONG_OUTPUT_LEN) begin
      len_clamped = LEN_W'(SONG_OUTPUT_LEN);
    end else begin
      len_clamped = LEN_W'(bus.SongLen);
    end
  end

  // Where to go once a note is finished (after GAP) or skipped (in WAIT).
  state_e            adv_state;
  logic [LEN_W-1:0]  adv_idx;
  logic [ADDR_W-1:0] adv_addr;
  logic              adv_fetch;

  always_comb begin
    adv_state = StFetch;
    adv_idx   = idx_inc;
    adv_addr  = ADDR_W'(idx_inc);
    adv_fetch = 1'b1;
    if (last_note) begin
`ifdef AMADEUS_PLAYER_LOOP_EN
      adv_state = StFetch;
      adv_idx   = '0;
      adv_addr  = '0;
      adv_fetch = 1'b1;
`else
      adv_state = StIdle;
      adv_idx   = '0;
      adv_addr  = rd_addr_q;
      adv_fetch = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    dur_d        = dur_q;
    tick_d       = tick_q;
    gap_d        = gap_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    note_on_d    = note_on_q;
    note_pitch_d = note_pitch_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.Start && !bus.Stop) begin
          len_d = len_clamped;
          idx_d = '0;
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = StFetch;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            busy_d    = 1'b1;
          end
        end
      end
      StFetch: begin
        state_d = StWait;
      end
      StWait: begin
        if (rd_dur == '0) begin
          state_d   = adv_state;
          idx_d     = adv_idx;
          rd_addr_d = adv_addr;
          rd_en_d   = adv_fetch;
          busy_d    = adv_fetch;
          done_d    = !adv_fetch;
        end else begin
          state_d      = StPlay;
          dur_d        = rd_dur;
          tick_d       = '0;
          note_pitch_d = rd_pitch;
          note_on_d    = (rd_pitch != '0);
        end
      end
      StPlay: begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          dur_d  = dur_q - BIT_LEN'(1);
          if (dur_q == BIT_LEN'(1)) begin
            state_d      = StGap;
            gap_d        = '0;
            note_on_d    = 1'b0;
            note_pitch_d = '0;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d   = adv_state;
          idx_d     = adv_idx;
          rd_addr_d = adv_addr;
          rd_en_d   = adv_fetch;
          busy_d    = adv_fetch;
          done_d    = !adv_fetch;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // Stop overrides everything; a read in flight is simply never captured.
    if (bus.Stop) begin
      state_d      = StIdle;
      idx_d        = '0;
      dur_d        = '0;
      tick_d       = '0;
      gap_d        = '0;
      rd_en_d      = 1'b0;
      note_on_d    = 1'b0;
      note_pitch_d = '0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      idx_q        <= '0;
      dur_q        <= '0;
      tick_q       <= '0;
      gap_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      note_on_q    <= 1'b0;
      note_pitch_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      dur_q        <= dur_d;
      tick_q       <= tick_d;
      gap_q        <= gap_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      note_on_q    <= note_on_d;
      note_pitch_q <= note_pitch_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.RdEn      = rd_en_q;
  assign bus.RdAddr    = rd_addr_q;
  assign bus.NoteOn    = note_on_q;
  assign bus.NotePitch = note_pitch_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule
